aq_dcache_tag_inv_ctrl: RTL

//  Front-end sequencer for the dcache tag array. Muxes normal LSU tag accesses with a
//  CP0-initiated invalidate-all sweep that clears valid bits, one set per cycle, all ways.

---
 rtl/aq_dcache_tag_inv_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/aq_dcache_tag_inv_ctrl.sv
// Dcache tag-array front end: muxes LSU tag accesses with a CP0 invalidate-all sweep.
// Optional AQ_DCACHE_INV_WAY_SEL_EN limits the sweep to a captured way mask.
module aq_dcache_tag_inv_ctrl #(
  parameter int SET_NUM = 64,
  parameter int WAY_NUM = 4,
  parameter int TAG_LEN = 28
) (
  input  logic                              forever_cpuclk,
  input  logic                              cpurst_b,
  input  logic                              cp0_lsu_dcache_inv,
`ifdef AQ_DCACHE_INV_WAY_SEL_EN
  input  logic [WAY_NUM-1:0]                cp0_lsu_dcache_inv_way,
`endif
  output logic                              lsu_cp0_inv_busy,
  output logic                              lsu_cp0_inv_done,
  input  logic                              lsu_tag_req,
  output logic                              lsu_tag_gnt,
  input  logic                              lsu_tag_gwen,
  input  logic [11:0]                       lsu_tag_idx,
  input  logic [WAY_NUM-1:0]                lsu_tag_way,
  input  logic [WAY_NUM*(TAG_LEN+2)-1:0]    lsu_tag_din,
  input  logic [WAY_NUM*(TAG_LEN+2)-1:0]    lsu_tag_wen,
  output logic                              tag_cen,
  output logic                              tag_clk_en,
  output logic                              tag_gwen,
  output logic [11:0]                       tag_idx,
  output logic [WAY_NUM-1:0]                tag_way,
  output logic [WAY_NUM*(TAG_LEN+2)-1:0]    tag_din,
  output logic [WAY_NUM*(TAG_LEN+2)-1:0]    tag_wen
);

  localparam int FLD_W = TAG_LEN + 2;
  localparam int DATA_W = WAY_NUM * FLD_W;
  localparam int CNT_W = $clog2(SET_NUM);
  localparam logic [CNT_W-1:0] LAST_SET = CNT_W'(SET_NUM - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   set_cnt, set_cnt_nxt;
  logic [WAY_NUM-1:0] sweep_way;
  logic [DATA_W-1:0]  sweep_wen;
  logic               inv_skip;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b) begin
      state   <= IDLE;
      set_cnt <= '0;
    end else begin
      state   <= state_nxt;
      set_cnt <= set_cnt_nxt;
    end
  end

`ifdef AQ_DCACHE_INV_WAY_SEL_EN
  logic [WAY_NUM-1:0] inv_way_q;

  always_ff @(posedge forever_cpuclk) begin
    if (!cpurst_b)
      inv_way_q <= '0;
    else if (state == IDLE && cp0_lsu_dcache_inv)
      inv_way_q <= cp0_lsu_dcache_inv_way;
  end

  assign sweep_way = inv_way_q;
  assign inv_skip  = (cp0_lsu_dcache_inv_way == '0);
`else
  assign sweep_way = '1;
  assign inv_skip  = 1'b0;
`endif

  // Only the valid bit (top bit of each way field) is write-enabled during a sweep.
  always_comb begin
    sweep_wen = '1;
    for (int w = 0; w < WAY_NUM; w++)
      sweep_wen[w*FLD_W + FLD_W - 1] = ~sweep_way[w];
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt        = state;
    set_cnt_nxt      = '0;
    lsu_cp0_inv_busy = 1'b0;
    lsu_cp0_inv_done = 1'b0;
    lsu_tag_gnt      = 1'b0;
    tag_cen          = 1'b1;
    tag_clk_en       = 1'b0;
    tag_gwen         = 1'b1;
    tag_idx          = '0;
    tag_way          = '0;
    tag_din          = '0;
    tag_wen          = '1;
    case (state)
      IDLE: begin
        if (cp0_lsu_dcache_inv) begin
          state_nxt = inv_skip ? DONE : SWEEP;
        end else if (lsu_tag_req) begin
          lsu_tag_gnt = 1'b1;
          tag_cen     = 1'b0;
          tag_clk_en  = 1'b1;
          tag_gwen    = lsu_tag_gwen;
          tag_idx     = lsu_tag_idx;
          tag_way     = lsu_tag_way;
          tag_din     = lsu_tag_din;
          tag_wen     = lsu_tag_wen;
        end
      end
      SWEEP: begin
        lsu_cp0_inv_busy = 1'b1;
        tag_cen          = 1'b0;
        tag_clk_en       = 1'b1;
        tag_gwen         = 1'b0;
        tag_idx[6 +: CNT_W] = set_cnt;
        tag_way          = sweep_way;
        tag_wen          = sweep_wen;
        if (set_cnt == LAST_SET)
          state_nxt = DONE;
        else
          set_cnt_nxt = set_cnt + 1'b1;
      end
      DONE: begin
        lsu_cp0_inv_done = 1'b1;
        state_nxt        = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
